// File: rtl/mac_pkg.sv
// Shared widths, saturation limits and word types for the MAC requantisation stage.
// Imported by mac_requant and its output buffer.
package mac_pkg;

  localparam int ACC_W   = 36;
  localparam int OUT_W   = 16;
  localparam int LEN_W   = 8;
  localparam int SHIFT_W = 6;
  localparam int WIDE_W  = ACC_W + 1;

  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [WIDE_W-1:0] wide_t;
  typedef logic signed [OUT_W-1:0]  out_t;

  localparam out_t OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam out_t OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  localparam logic [SHIFT_W-1:0] SHIFT_MAX = SHIFT_W'(ACC_W - 1);

  // One buffered result: the saturation marker travels with its data word.
  typedef struct packed {
    logic sat;
    out_t data;
  } res_t;

  function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] sh);
    return (sh > SHIFT_MAX) ? SHIFT_MAX : sh;
  endfunction

  function automatic res_t saturate(input wide_t v);
    res_t r;
    if (v > wide_t'(OUT_MAX)) begin
      r.sat  = 1'b1;
      r.data = OUT_MAX;
    end else if (v < wide_t'(OUT_MIN)) begin
      r.sat  = 1'b1;
      r.data = OUT_MIN;
    end else begin
      r.sat  = 1'b0;
      r.data = v[OUT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_requant_fifo2.sv
// Two-entry valid/ready result buffer; a write while full only lands if the
// head is popped on the same edge.
module mac_requant_fifo2
  import mac_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic wr_en,
  input  res_t wr_data,
  output logic full,
  output logic rd_valid,
  input  logic rd_ready,
  output res_t rd_data
);

  res_t       mem_q [2];
  res_t       mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  always_comb begin
    full     = (count_q == 2'd2);
    rd_valid = (count_q != 2'd0);
    rd_data  = mem_q[rd_ptr_q];
    pop      = rd_valid & rd_ready;
    push     = wr_en & (~full | pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mac_requant.sv
// Requantisation stage behind the MAC accumulator: finds the last beat of each
// dot product, rounds/shifts/saturates the sum and queues it for the consumer.
module mac_requant
  import mac_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [ACC_W-1:0]   acc_in,
  input  logic                      acc_vld,
  input  logic        [LEN_W-1:0]   cfg_len,
  input  logic        [SHIFT_W-1:0] cfg_shift,
  output logic                      acc_clr,
  output logic signed [OUT_W-1:0]   out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sat_flag,
  output logic                      overflow_err,
  output logic                      busy
);

  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic               clr_q, clr_d;
  acc_t               s1_q, s1_d;
  logic [SHIFT_W-1:0] s1_sh_q, s1_sh_d;
  logic               s1_v_q, s1_v_d;
  wide_t              s2_q, s2_d;
  logic               s2_v_q, s2_v_d;
  res_t               s3_q, s3_d;
  logic               s3_v_q, s3_v_d;
  logic               ovf_q, ovf_d;

  logic               first_beat;
  logic [LEN_W-1:0]   cur_len;
  logic [LEN_W-1:0]   len_m1;
  logic [SHIFT_W-1:0] cur_shift;
  logic               last_beat;
  wide_t              round_add;
  wide_t              sum_w;

  logic               fifo_full;
  logic               fifo_valid;
  res_t               fifo_head;
  logic               pop;

  // On the first beat of a frame the live config is used and latched, so a
  // one-beat frame and the following frame can each carry their own settings.
  always_comb begin
    first_beat = (cnt_q == '0);
    cur_len    = first_beat ? cfg_len : len_q;
    cur_shift  = first_beat ? clamp_shift(cfg_shift) : shift_q;
    len_m1     = cur_len - LEN_W'(1);
    last_beat  = acc_vld & (cnt_q == len_m1);

    len_d   = len_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (acc_vld) begin
      if (first_beat) begin
        len_d   = cfg_len;
        shift_d = cur_shift;
      end
      cnt_d = last_beat ? '0 : cnt_q + LEN_W'(1);
    end
    clr_d = last_beat;

    s1_d    = last_beat ? acc_in : s1_q;
    s1_sh_d = last_beat ? cur_shift : s1_sh_q;
    s1_v_d  = last_beat;

    // Half-LSB offset before the arithmetic shift gives round-half-up.
    round_add = (s1_sh_q == '0) ? '0 : (wide_t'(1) << (s1_sh_q - SHIFT_W'(1)));
    sum_w     = wide_t'(s1_q) + round_add;
    s2_d      = sum_w >>> s1_sh_q;
    s2_v_d    = s1_v_q;

    s3_d   = saturate(s2_q);
    s3_v_d = s2_v_q;

    pop   = fifo_valid & out_ready;
    ovf_d = ovf_q | (s3_v_q & fifo_full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      len_q   <= '0;
      shift_q <= '0;
      clr_q   <= 1'b0;
      s1_q    <= '0;
      s1_sh_q <= '0;
      s1_v_q  <= 1'b0;
      s2_q    <= '0;
      s2_v_q  <= 1'b0;
      s3_q    <= '0;
      s3_v_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      shift_q <= shift_d;
      clr_q   <= clr_d;
      s1_q    <= s1_d;
      s1_sh_q <= s1_sh_d;
      s1_v_q  <= s1_v_d;
      s2_q    <= s2_d;
      s2_v_q  <= s2_v_d;
      s3_q    <= s3_d;
      s3_v_q  <= s3_v_d;
      ovf_q   <= ovf_d;
    end
  end

  mac_requant_fifo2 u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (s3_v_q),
    .wr_data  (s3_q),
    .full     (fifo_full),
    .rd_valid (fifo_valid),
    .rd_ready (out_ready),
    .rd_data  (fifo_head)
  );

  always_comb begin
    acc_clr      = clr_q;
    out_data     = fifo_head.data;
    sat_flag     = fifo_head.sat;
    out_valid    = fifo_valid;
    overflow_err = ovf_q;
    busy         = (cnt_q != '0) | s1_v_q | s2_v_q | s3_v_q | fifo_valid;
  end

endmodule

// File: tb/tb_mac_requant.sv
// Scoreboard bench for mac_requant: a frame-level reference model predicts each
// requantised result, a monitor compares whatever the buffer hands out.
module tb_mac_requant;
  import mac_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic signed [ACC_W-1:0]   acc_in;
  logic                      acc_vld;
  logic        [LEN_W-1:0]   cfg_len;
  logic        [SHIFT_W-1:0] cfg_shift;
  logic                      acc_clr;
  logic signed [OUT_W-1:0]   out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic                      sat_flag;
  logic                      overflow_err;
  logic                      busy;

  always #5 clk = ~clk;

  mac_requant dut (
    .clk          (clk),
    .rst          (rst),
    .acc_in       (acc_in),
    .acc_vld      (acc_vld),
    .cfg_len      (cfg_len),
    .cfg_shift    (cfg_shift),
    .acc_clr      (acc_clr),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .sat_flag     (sat_flag),
    .overflow_err (overflow_err),
    .busy         (busy)
  );

  int          checks = 0;
  int          passes = 0;
  logic [16:0] exp_q [$];
  int          m_cnt = 0;
  int          m_len = 1;
  int          m_shift = 0;
  int          m_frames = 0;
  bit          drop_next = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
  endtask

  // Reference: divide by 2^sh after adding half, floor toward -inf, then clamp.
  function automatic logic [16:0] refResult(input logic signed [ACC_W-1:0] a, input int sh);
    longint v, d, num, q;
    int     s;
    v = a;
    s = (sh > ACC_W - 1) ? ACC_W - 1 : sh;
    if (s == 0) begin
      q = v;
    end else begin
      d   = longint'(1) << s;
      num = v + d / 2;
      q   = num / d;
      if ((num % d) != 0 && num < 0) q = q - 1;
    end
    if (q > 32767) return {1'b1, 16'h7fff};
    if (q < -32768) return {1'b1, 16'h8000};
    return {1'b0, 16'(q)};
  endfunction

  // Drives one cycle of inputs, advances the frame model, checks acc_clr.
  task automatic applyStimulus(input logic vld, input logic signed [ACC_W-1:0] acc, input logic rdy);
    bit last_exp;
    last_exp  = 1'b0;
    acc_vld   = vld;
    acc_in    = acc;
    out_ready = rdy;
    if (vld) begin
      if (m_cnt == 0) begin
        m_len   = (cfg_len == 0) ? 256 : int'(cfg_len);
        m_shift = int'(cfg_shift);
      end
      m_cnt++;
      if (m_cnt == m_len) begin
        last_exp = 1'b1;
        m_cnt    = 0;
        m_frames++;
        if (!drop_next) exp_q.push_back(refResult(acc, m_shift));
      end
    end
    @(posedge clk);
    #1;
    checkOutput("acc_clr", 64'(acc_clr), 64'(last_exp));
  endtask

  task automatic doReset();
    rst     = 1'b1;
    acc_vld = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_cnt = 0;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_data", 64'(out_data), 64'd0);
    checkOutput("rst_sat_flag", 64'(sat_flag), 64'd0);
    checkOutput("rst_acc_clr", 64'(acc_clr), 64'd0);
    checkOutput("rst_overflow_err", 64'(overflow_err), 64'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 64) begin
      applyStimulus(1'b0, '0, 1'b1);
      n++;
    end
    checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (6) applyStimulus(1'b0, '0, 1'b1);
  endtask

  function automatic logic signed [ACC_W-1:0] randAcc();
    logic signed [19:0]      small_v;
    logic signed [31:0]      mid_v;
    logic signed [ACC_W-1:0] r;
    case ($urandom_range(2, 0))
      0: begin small_v = 20'($urandom); r = small_v; end
      1: begin mid_v = $urandom; r = mid_v; end
      default: r = {4'($urandom), 32'($urandom)};
    endcase
    return r;
  endfunction

  // Monitor: every accepted transfer must match the oldest predicted result.
  initial begin
    logic [16:0] exp_v;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_result actual=%0h required=none at %0t",
                   {sat_flag, out_data}, $time);
        end else begin
          exp_v = exp_q.pop_front();
          checkOutput("result", 64'({sat_flag, out_data}), 64'(exp_v));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int low_run;
    int cycles;
    logic vld;
    logic rdy;

    rst       = 1'b1;
    acc_vld   = 1'b0;
    acc_in    = '0;
    cfg_len   = 8'd4;
    cfg_shift = 6'd0;
    out_ready = 1'b1;
    @(posedge clk);
    doReset();

    // Basic frame and latency
    cfg_len   = 8'd4;
    cfg_shift = 6'd0;
    applyStimulus(1'b1, 36'sd10, 1'b1);
    checkOutput("busy_mid_frame", 64'(busy), 64'd1);
    applyStimulus(1'b1, 36'sd20, 1'b1);
    applyStimulus(1'b1, 36'sd30, 1'b1);
    applyStimulus(1'b1, 36'sd1000, 1'b1);
    checkOutput("lat_e0_valid", 64'(out_valid), 64'd0);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("lat_e1_valid", 64'(out_valid), 64'd0);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("lat_e2_valid", 64'(out_valid), 64'd0);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("lat_e3_valid", 64'(out_valid), 64'd1);
    checkOutput("basic_data", 64'(out_data), 64'd1000);
    drain();

    // Rounding with single-beat frames
    cfg_len   = 8'd1;
    cfg_shift = 6'd4;
    applyStimulus(1'b1, 36'sd24, 1'b1);
    applyStimulus(1'b1, -36'sd24, 1'b1);
    applyStimulus(1'b1, 36'sd23, 1'b1);
    drain();

    // Saturation and shift clamp
    cfg_shift = 6'd0;
    applyStimulus(1'b1, 36'sh1_0000_0000, 1'b1);
    applyStimulus(1'b1, -36'sd40000, 1'b1);
    cfg_shift = 6'd35;
    applyStimulus(1'b1, -36'sd1, 1'b1);
    cfg_shift = 6'd63;
    applyStimulus(1'b1, 36'sh7_FFFF_FFFF, 1'b1);
    drain();

    // Backpressure: third result finds the buffer full and is lost
    cfg_len   = 8'd1;
    cfg_shift = 6'd0;
    applyStimulus(1'b1, 36'sd1, 1'b0);
    applyStimulus(1'b1, 36'sd2, 1'b0);
    drop_next = 1'b1;
    applyStimulus(1'b1, 36'sd3, 1'b0);
    drop_next = 1'b0;
    repeat (5) applyStimulus(1'b0, '0, 1'b0);
    checkOutput("bp_overflow", 64'(overflow_err), 64'd1);
    checkOutput("bp_valid", 64'(out_valid), 64'd1);
    checkOutput("bp_head", 64'(out_data), 64'd1);
    drain();
    checkOutput("bp_overflow_sticky", 64'(overflow_err), 64'd1);
    doReset();

    // Reset mid-frame discards the partial frame
    cfg_len = 8'd4;
    applyStimulus(1'b1, 36'sd5, 1'b1);
    applyStimulus(1'b1, 36'sd6, 1'b1);
    doReset();
    applyStimulus(1'b1, 36'sd1, 1'b1);
    applyStimulus(1'b1, 36'sd2, 1'b1);
    applyStimulus(1'b1, 36'sd3, 1'b1);
    applyStimulus(1'b1, 36'sd7, 1'b1);
    drain();

    // Length 0 means 256 beats; a mid-frame length change is ignored
    cfg_len   = 8'd0;
    cfg_shift = 6'd0;
    for (int i = 0; i < 256; i++) begin
      if (i == 100) cfg_len = 8'd3;
      applyStimulus(1'b1, 36'(i + 1), 1'b1);
      if (i == 254) checkOutput("len0_not_early", 64'(busy), 64'd1);
    end
    drain();

    // Randomised frames with live config churn and short ready gaps
    low_run = 0;
    cycles  = 0;
    m_frames = 0;
    while (m_frames < 40 && cycles < 5000) begin
      cfg_len   = LEN_W'($urandom_range(10, 4));
      cfg_shift = SHIFT_W'($urandom_range(63, 0));
      vld = ($urandom_range(9, 0) < 7);
      rdy = 1'b1;
      if (low_run < 2 && $urandom_range(3, 0) == 0) rdy = 1'b0;
      low_run = rdy ? 0 : low_run + 1;
      applyStimulus(vld, randAcc(), rdy);
      cycles++;
    end
    checkOutput("rand_frames_done", 64'(m_frames >= 40), 64'd1);
    while (m_cnt != 0 && cycles < 6000) begin
      applyStimulus(1'b1, randAcc(), 1'b1);
      cycles++;
    end
    drain();
    checkOutput("rand_no_overflow", 64'(overflow_err), 64'd0);
    checkOutput("final_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
